dual_requester_route_arbiter: RTL and testbench

Shares the left/right output datapath between two independent requesters, A and B, using round-robin arbitration.
The granted requester opens a session. Its first confirmed word selects the destination (din[0]: 0 = left, 1 = right). Each later confirmed word is forwarded to that destination with a one-cycle enable strobe.
Sessions end when the owner drops rqst, when the beat cap is reached, or on confirm timeout. The block sits between the request sources and the left/right sinks of the lab system.

---
 rtl/dual_requester_route_arbiter_pkg.sv | 18 +
 rtl/dual_requester_route_arbiter_rr_arbiter2.sv | 31 +++
 rtl/dual_requester_route_arbiter.sv | 145 ++++++++++++++
 tb/tb_dual_requester_route_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dual_requester_route_arbiter_pkg.sv
// Shared encodings for the dual-requester route arbiter: FSM states,
// destination select values and requester side identifiers.
package dual_requester_route_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic DEST_LEFT  = 1'b0;
  localparam logic DEST_RIGHT = 1'b1;

  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

endpackage

// File: rtl/dual_requester_route_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered
// record of the side most recently granted (B after reset, so A wins first tie).
module rr_arbiter2
  import dual_requester_route_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       load,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == SIDE_B) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_grant <= SIDE_B;
    else if (load && (req != 2'b00))
      last_grant <= grant[1];
  end

endmodule

// File: rtl/dual_requester_route_arbiter.sv
// Shares the left/right output datapath between requesters A and B; the
// granted side picks a destination with its first word, then streams beats.
module dual_requester_route_arbiter
  import dual_requester_route_arbiter_pkg::*;
#(
  parameter int unsigned DW        = 4,
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned TIMEOUT   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rqst_a,
  input  logic          confirm_a,
  input  logic [DW-1:0] din_a,
  input  logic          rqst_b,
  input  logic          confirm_b,
  input  logic [DW-1:0] din_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          en_left,
  output logic          en_right,
  output logic [DW-1:0] dout_left,
  output logic [DW-1:0] dout_right,
  output logic          busy,
  output logic          timeout_err
);

  localparam logic [3:0] BEAT_LAST = 4'(MAX_BEATS - 1);
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

  state_t        state;
  logic          dest;
  logic [3:0]    beat_cnt;
  logic [7:0]    idle_cnt;
  logic [1:0]    grant;
  logic          last_grant;
  logic          own_rqst;
  logic          own_confirm;
  logic [DW-1:0] own_din;
  logic          idle_expire;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({rqst_b, rqst_a}),
    .load       (state == IDLE),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // last_grant is updated on the grant edge, so it names the current owner
  always_comb begin
    own_rqst    = (last_grant == SIDE_B) ? rqst_b    : rqst_a;
    own_confirm = (last_grant == SIDE_B) ? confirm_b : confirm_a;
    own_din     = (last_grant == SIDE_B) ? din_b     : din_a;
    idle_expire = (idle_cnt == IDLE_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dest        <= DEST_LEFT;
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      en_left     <= 1'b0;
      en_right    <= 1'b0;
      dout_left   <= '0;
      dout_right  <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      en_left     <= 1'b0;
      en_right    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            gnt_a    <= grant[0];
            gnt_b    <= grant[1];
            busy     <= 1'b1;
            idle_cnt <= '0;
            beat_cnt <= '0;
            state    <= SELECT;
          end
        end
        SELECT: begin
          if (!own_rqst) begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            state <= RELEASE;
          end else if (own_confirm) begin
            dest     <= own_din[0];
            idle_cnt <= '0;
            beat_cnt <= '0;
            state    <= XFER;
          end else if (idle_expire) begin
            timeout_err <= 1'b1;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            state       <= RELEASE;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        XFER: begin
          if (!own_rqst) begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            state <= RELEASE;
          end else if (own_confirm) begin
            idle_cnt <= '0;
            beat_cnt <= beat_cnt + 4'd1;
            if (dest == DEST_RIGHT) begin
              dout_right <= own_din;
              en_right   <= 1'b1;
            end else begin
              dout_left <= own_din;
              en_left   <= 1'b1;
            end
            if (beat_cnt == BEAT_LAST) begin
              gnt_a <= 1'b0;
              gnt_b <= 1'b0;
              state <= RELEASE;
            end
          end else if (idle_expire) begin
            timeout_err <= 1'b1;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            state       <= RELEASE;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_requester_route_arbiter.sv
// Directed bench for dual_requester_route_arbiter; forwarded beats are
// predicted into a scoreboard queue and matched against observed strobes.
module tb_dual_requester_route_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       rqst_a, confirm_a, rqst_b, confirm_b;
  logic [3:0] din_a, din_b;
  logic       gnt_a, gnt_b, en_left, en_right, busy, timeout_err;
  logic [3:0] dout_left, dout_right;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] sb[$];  // {side (1 = right), data}

  dual_requester_route_arbiter #(.DW(4), .MAX_BEATS(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .rqst_a(rqst_a), .confirm_a(confirm_a), .din_a(din_a),
    .rqst_b(rqst_b), .confirm_b(confirm_b), .din_b(din_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .en_left(en_left), .en_right(en_right),
    .dout_left(dout_left), .dout_right(dout_right),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] all_outs();
    return {gnt_a, gnt_b, en_left, en_right, busy, timeout_err, dout_left, dout_right};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("gnt_onehot", {31'd0, gnt_a & gnt_b}, 32'd0);
      check("en_onehot", {31'd0, en_left & en_right}, 32'd0);
      if (en_left || en_right) begin
        if (sb.size() == 0) begin
          check("unexp_strobe", {30'd0, en_right, en_left}, 32'd0);
        end else begin
          logic [4:0] e;
          e = sb.pop_front();
          check("strobe", {27'd0, en_right, en_right ? dout_right : dout_left}, {27'd0, e});
        end
      end
    end
  end

  initial begin
    int cycles;
    rst = 1'b0;
    {rqst_a, confirm_a, rqst_b, confirm_b, din_a, din_b} = '0;

    // 1. reset with random inputs
    for (int i = 0; i < 4; i++) begin
      {rqst_a, confirm_a, rqst_b, confirm_b, din_a, din_b} = 12'($urandom);
      tick();
      check("reset_outs", {18'd0, all_outs()}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    {rqst_a, confirm_a, rqst_b, confirm_b, din_a, din_b} = '0;
    rqst_a = 1'b1;
    tick();
    check("t1_gnt", {29'd0, gnt_a, gnt_b, busy}, 32'b101);

    // 2. A alone to the left
    confirm_a = 1'b1; din_a = 4'b1010;
    tick();
    check("t2_sel_noen", {30'd0, en_left, en_right}, 32'd0);
    din_a = 4'd3; sb.push_back({1'b0, 4'd3});
    tick();
    check("t2_beat1", {27'd0, en_left, dout_left}, {27'd0, 1'b1, 4'd3});
    din_a = 4'd5; sb.push_back({1'b0, 4'd5});
    tick();
    check("t2_beat2", {27'd0, en_left, dout_left}, {27'd0, 1'b1, 4'd5});
    confirm_a = 1'b0; rqst_a = 1'b0;
    tick();
    check("t2_release", {24'd0, gnt_a, gnt_b, en_left, en_right, dout_left}, {24'd0, 4'b0000, 4'd5});
    check("t2_rel_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t2_idle_busy", {31'd0, busy}, 32'd0);

    // 3. simultaneous requests from reset; A first, B after RELEASE
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t3_reset_clear", {18'd0, all_outs()}, 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    rqst_a = 1'b1; rqst_b = 1'b1; confirm_b = 1'b1; din_b = 4'hF;
    tick();
    check("t3_gnt_a", {30'd0, gnt_a, gnt_b}, 32'b10);
    confirm_a = 1'b1; din_a = 4'b0000;
    tick();
    for (int i = 0; i < 4; i++) begin
      din_a = 4'(6 + i); sb.push_back({1'b0, 4'(6 + i)});
      tick();
    end
    check("t3_a_done", {22'd0, gnt_a, gnt_b, dout_left, dout_right}, {22'd0, 2'b00, 4'd9, 4'd0});
    confirm_a = 1'b0;
    tick();
    check("t3_idle", {29'd0, gnt_a, gnt_b, busy}, 32'd0);
    din_b = 4'b1011;
    tick();
    check("t3_gnt_b", {30'd0, gnt_a, gnt_b}, 32'b01);
    rqst_a = 1'b0;

    // 4. B to the right, beat cap drops word 5
    tick();
    for (int i = 1; i <= 5; i++) begin
      din_b = 4'(i);
      if (i <= 4) sb.push_back({1'b1, 4'(i)});
      tick();
    end
    check("t4_cap", {25'd0, gnt_b, en_right, en_left, dout_right}, {25'd0, 3'b000, 4'd4});
    rqst_b = 1'b0; confirm_b = 1'b0;
    tick();
    check("t4_idle_busy", {31'd0, busy}, 32'd0);

    // 5. timeout after a left select
    rqst_a = 1'b1;
    tick();
    check("t5_gnt", {31'd0, gnt_a}, 32'd1);
    confirm_a = 1'b1; din_a = 4'b0000;
    tick();
    confirm_a = 1'b0;
    cycles = 0;
    while (!timeout_err && cycles < 20) begin
      tick();
      cycles++;
      if (!timeout_err) check("t5_hold_gnt", {31'd0, gnt_a}, 32'd1);
    end
    check("t5_cycles", 32'(cycles), 32'd8);
    check("t5_gnt_fall", {30'd0, timeout_err, gnt_a}, 32'b10);
    rqst_a = 1'b0;
    tick();
    check("t5_pulse_once", {31'd0, timeout_err}, 32'd0);
    tick();

    // 6. asynchronous reset mid-XFER
    rqst_a = 1'b1;
    tick();
    confirm_a = 1'b1; din_a = 4'b0001;
    tick();
    din_a = 4'd6; sb.push_back({1'b1, 4'd6});
    tick();
    check("t6_beat", {27'd0, en_right, dout_right}, {27'd0, 1'b1, 4'd6});
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_clear", {18'd0, all_outs()}, 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    rqst_a = 1'b0; confirm_a = 1'b0; rqst_b = 1'b1;
    tick();
    check("t6_gnt_b", {29'd0, gnt_a, gnt_b, busy}, 32'b011);
    rqst_b = 1'b0;
    tick();
    tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
